// File: rtl/entropy_bitstream_packer.sv
// Output stage of the entropy encoder: gathers 0..IN_LANES bytes per cycle into a
// circular byte buffer and emits OUT_BYTES-wide words over valid/ready, closing each
// stream with a byte-counted final word.
module entropy_bitstream_packer #(
    parameter int unsigned IN_LANES   = 5,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned OUT_BYTES  = 4,
    parameter int unsigned BUF_DEPTH  = 16,
    parameter int unsigned CNT_WIDTH  = 3
) (
    input  logic                                top_clk,
    input  logic                                top_reset,
    input  logic [IN_LANES*BYTE_WIDTH-1:0]      in_bytes,
    input  logic [CNT_WIDTH-1:0]                in_count,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic [OUT_BYTES*BYTE_WIDTH-1:0]     out_data,
    output logic [$clog2(OUT_BYTES+1)-1:0]      out_bytes,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(BUF_DEPTH+1)-1:0]      level,
    output logic                                overflow
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned LVL_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OB_W  = $clog2(OUT_BYTES + 1);
    localparam int unsigned OUT_W = OUT_BYTES * BYTE_WIDTH;

    localparam logic [CNT_WIDTH-1:0] LANES_MAX = CNT_WIDTH'(IN_LANES);
    localparam logic [LVL_W-1:0]     DEPTH_L   = LVL_W'(BUF_DEPTH);
    localparam logic [LVL_W-1:0]     LANES_L   = LVL_W'(IN_LANES);
    localparam logic [LVL_W-1:0]     OUTB_L    = LVL_W'(OUT_BYTES);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_LAST_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [BYTE_WIDTH-1:0]  mem_q [BUF_DEPTH];
    logic [BYTE_WIDTH-1:0]  mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       count_q, count_d;
    logic [OUT_W-1:0]       out_data_q, out_data_d;
    logic [OB_W-1:0]        out_bytes_q, out_bytes_d;
    logic                   out_last_q, out_last_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overflow_q, overflow_d;

    logic [CNT_WIDTH-1:0]   n_in_c;
    logic                   accept_c;
    logic                   drop_c;
    logic                   load_c;
    logic [OB_W-1:0]        n_pop_c;
    logic                   pop_last_c;
    logic                   can_load_c;

    // Input qualification: clamp lane count, decide accept vs drop.
    always_comb begin
        n_in_c   = (in_count > LANES_MAX) ? LANES_MAX : in_count;
        in_ready = (state_q == ST_RUN) && ((DEPTH_L - count_q) >= LANES_L);
        accept_c = in_ready && (n_in_c != '0);
        drop_c   = !in_ready && (n_in_c != '0);
    end

    // Stream-state next-state and output-register load decision.
    always_comb begin
        state_d    = state_q;
        load_c     = 1'b0;
        n_pop_c    = '0;
        pop_last_c = 1'b0;
        can_load_c = !out_valid_q || out_ready;
        case (state_q)
            ST_RUN: begin
                if (can_load_c && (count_q >= OUTB_L)) begin
                    load_c  = 1'b1;
                    n_pop_c = OB_W'(OUT_BYTES);
                end
                if (in_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (can_load_c) begin
                    load_c = 1'b1;
                    if (count_q > OUTB_L) begin
                        n_pop_c = OB_W'(OUT_BYTES);
                    end else begin
                        // This word empties the buffer (possibly zero bytes) and ends the stream.
                        n_pop_c    = OB_W'(count_q);
                        pop_last_c = 1'b1;
                        state_d    = ST_LAST_WAIT;
                    end
                end
            end
            ST_LAST_WAIT: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Buffer, pointer, level and output-register datapath.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q | drop_c;

        for (int j = 0; j < IN_LANES; j++) begin
            if (accept_c && (32'(j) < 32'(n_in_c))) begin
                mem_d[PTR_W'(wr_ptr_q + PTR_W'(j))] = in_bytes[j*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (accept_c) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(n_in_c));
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (load_c) begin
            out_valid_d = 1'b1;
            out_bytes_d = n_pop_c;
            out_last_d  = pop_last_c;
            out_data_d  = '0;
            for (int i = 0; i < OUT_BYTES; i++) begin
                if (32'(i) < 32'(n_pop_c)) begin
                    out_data_d[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_q[PTR_W'(rd_ptr_q + PTR_W'(i))];
                end
            end
            rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(n_pop_c));
        end

        count_d = count_q + (accept_c ? LVL_W'(n_in_c) : LVL_W'(0)) - LVL_W'(n_pop_c);

        // Final word handed off: restart the next stream from a clean buffer.
        if ((state_q == ST_LAST_WAIT) && out_valid_q && out_ready) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge top_clk or posedge top_reset) begin
        if (top_reset) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int k = 0; k < BUF_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign level     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/entropy_bitstream_packer.md
# entropy_bitstream_packer

Parametrised output stage for the entropy encoder. It accepts a variable number of bitstream bytes per cycle (0..IN_LANES, as produced by the carry-propagation stage) and buffers them in a circular byte buffer. It emits fixed-width OUT_BYTES words over a valid/ready handshake, and closes the stream on a final flag by flushing a partial, byte-counted last word. Unlike the fixed five-output encoder top, lane count, word width and buffer depth are parameters, downstream backpressure is supported, and byte loss is reported.

## Interface

Parameters:
- IN_LANES, 5, maximum bytes accepted per cycle
- BYTE_WIDTH, 8, width of one bitstream byte
- OUT_BYTES, 4, bytes per output word
- BUF_DEPTH, 16, buffer capacity in bytes; must be a power of 2 and ≥ IN_LANES+OUT_BYTES
- CNT_WIDTH, 3, width of in_count; must satisfy 2^CNT_WIDTH > IN_LANES

Ports:
- top_clk  in  1  single clock; all state on rising edge
- top_reset  in  1  asynchronous, active-high reset
- in_bytes  in  IN_LANES*BYTE_WIDTH  lane 0 in bits [BYTE_WIDTH-1:0], oldest byte
- in_count  in  CNT_WIDTH  number of valid lanes, starting at lane 0; values > IN_LANES are clamped to IN_LANES
- in_last  in  1  end of stream; bytes presented in the same cycle belong to the stream
- in_ready  out  1  free space ≥ IN_LANES and state is RUN
- out_data  out  OUT_BYTES*BYTE_WIDTH  oldest byte in the LSBs; unused bytes are zero
- out_bytes  out  $clog2(OUT_BYTES+1)  valid bytes in out_data
- out_last  out  1  final word of the stream
- out_valid  out  1  output word present
- out_ready  in  1  downstream accepts the word
- level  out  $clog2(BUF_DEPTH+1)  bytes currently buffered, excluding the output register
- overflow  out  1  sticky; set when bytes are dropped

## Operation

- Buffer: byte array with wr_ptr, rd_ptr and count. Pointers wrap modulo BUF_DEPTH.
- Input is accepted when in_ready=1. The in_count bytes are written at wr_ptr..wr_ptr+in_count-1, with wrap.
- If in_count>0 while in_ready=0:
  - all bytes of that cycle are dropped,
  - overflow is set,
  - in_last in the same cycle is still honoured if the state is RUN.
- Output register load: occurs when (!out_valid || out_ready), subject to the state rules below. Loading pops the bytes from the buffer.
- Same-cycle push and pop: count_next = count + pushed − popped. in_ready is computed from the current count only, which is conservative.
- States:
  - RUN:
    - load a full word when count ≥ OUT_BYTES;
    - on in_last, go to FLUSH.
  - FLUSH:
    - input is not accepted;
    - load words of min(count, OUT_BYTES) bytes;
    - the word that empties the buffer has out_last=1;
    - if count=0 on entry, load one word with out_bytes=0, out_data=0, out_last=1;
    - after loading the last word, go to LAST_WAIT.
  - LAST_WAIT:
    - input is not accepted;
    - on the out_valid&&out_ready handshake of the last word, go to RUN with pointers cleared.
- in_last outside RUN is ignored.
- Output stability: out_data, out_bytes and out_last are stable while out_valid && !out_ready.
- overflow clears only on reset.

## Timing

- Reset (asynchronous, immediate):
  - out_valid=0, out_data=0, out_bytes=0, out_last=0, level=0, overflow=0;
  - state=RUN, so in_ready=1 (combinational from state and count).
- Latency: bytes sampled at edge k land in the buffer. The earliest load into the output register is edge k+1, so out_valid rises after edge k+1.
- With out_ready held at 1, throughput is one word per cycle.
- in_last at edge k with count+pushed ≤ OUT_BYTES: out_last word is valid after edge k+1.
- level and overflow update on the edge where the push/pop/drop occurs.
- Reset mid-operation (any state): all state is cleared asynchronously. No partial word is emitted.

## Test plan

- Reset: assert top_reset with no clock, then release. Required: out_valid=0, in_ready=1, level=0, overflow=0.
- Streaming with wrap: in_count sequence 5,3 carrying bytes 0x01..0x08, out_ready=1. Required:
  - out_data 0x04030201 then 0x08070605, out_bytes=4, out_last=0;
  - first word valid after the edge following the first input.
  - Repeat for 40 bytes so that pointers wrap; output byte order must be preserved.
- Partial flush: bytes 0xA0..0xA4 (count 5), then 0xA5 (count 1) together with in_last. Required:
  - 0xA3A2A1A0 with out_bytes=4, out_last=0;
  - then 0x0000A5A4 with out_bytes=2, out_last=1;
  - in_ready stays 0 until that handshake, then returns to 1.
- Empty flush: in_last with in_count=0 on an empty buffer. Required: a single word with out_data=0, out_bytes=0, out_last=1.
- Backpressure and overflow: out_ready=0, 5 bytes per cycle. Required:
  - in_ready falls once level > 11;
  - the held word remains stable;
  - driving count 5 while in_ready=0 sets overflow=1 and leaves level unchanged;
  - after releasing out_ready, the remaining data drains in order.
- Async reset during LAST_WAIT with out_valid=1. Required: out_valid and out_last drop to 0 before the next clock edge, and no word is emitted after reset.
